// File: rtl/hs_rx_buffer.sv
// Destination-side receiver for the handshake synchronizer: edge-captures dvalid into a FWFT FIFO.
// Optional saturating drop counter built when HS_RX_DROP_CNT_EN is defined.
module hs_rx_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dvalid,
    input  logic [WIDTH-1:0]           dout,
    output logic                       dbusy,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count_next;
    logic             dvalid_q;
    logic             cap, pop, push, drop, full;

    // One capture per dvalid high period, however long it lasts.
    assign cap  = dvalid & ~dvalid_q;
    assign full = (count == CW'(DEPTH));
    assign pop  = out_valid & out_ready;
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    assign out_valid = (count != '0);
    assign out_data  = mem[rptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvalid_q <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            dbusy    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            dvalid_q <= dvalid;
            count    <= count_next;
            // One slot of margin absorbs a transfer already in flight.
            dbusy    <= (count_next >= CW'(DEPTH - 1));
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wptr] <= dout;
    end

`ifdef HS_RX_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_hs_rx_buffer.sv
// Directed plus randomized bench for hs_rx_buffer against a queue-based reference model.
module tb_hs_rx_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n, dvalid, out_ready;
    logic [WIDTH-1:0] dout;
    logic             dbusy, out_valid, overflow;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic [7:0]       drop_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    bit               m_prev, m_ovf;
    int               m_drops;

    always #5 clk = ~clk;

    hs_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .dvalid(dvalid), .dout(dout), .dbusy(dbusy),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_drops();
`ifdef HS_RX_DROP_CNT_EN
        return (m_drops > 255) ? 8'd255 : 8'(m_drops);
`else
        return 8'd0;
`endif
    endfunction

    // Drive inputs, take one clock edge, advance the model, then compare everything.
    task automatic step(input logic r, input logic dv, input logic [WIDTH-1:0] d, input logic rdy);
        bit cap, pp;
        rst_n = r; dvalid = dv; dout = d; out_ready = rdy;
        @(posedge clk);
        if (!r) begin
            q.delete(); m_prev = 0; m_ovf = 0; m_drops = 0;
        end else begin
            cap = dv && !m_prev;
            pp  = (q.size() != 0) && rdy;
            if (pp) void'(q.pop_front());
            if (cap) begin
                if (q.size() < DEPTH) q.push_back(d);
                else begin m_ovf = 1; m_drops++; end
            end
            m_prev = dv;
        end
        #1;
        chk("count", WIDTH'(count), WIDTH'(q.size()));
        chk("out_valid", WIDTH'(out_valid), WIDTH'(q.size() != 0));
        chk("dbusy", WIDTH'(dbusy), WIDTH'(q.size() >= DEPTH - 1));
        chk("overflow", WIDTH'(overflow), WIDTH'(m_ovf));
        chk("drop_cnt", WIDTH'(drop_cnt), WIDTH'(exp_drops()));
        if (q.size() != 0) chk("out_data", out_data, q[0]);
    endtask

    task automatic xfer(input logic [WIDTH-1:0] d, input int hi, input logic rdy);
        for (int i = 0; i < hi; i++) step(1, 1, d, rdy);
        step(1, 0, d, rdy);
    endtask

    task automatic pop_expect(input logic [WIDTH-1:0] exp);
        chk("drain_valid", WIDTH'(out_valid), 1);
        chk("drain_data", out_data, exp);
        step(1, 0, '0, 1);
    endtask

    initial begin
        logic dv;
        logic [WIDTH-1:0] d;
        m_prev = 0; m_ovf = 0; m_drops = 0;

        // Reset
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        chk("rst_count", WIDTH'(count), 0);
        chk("rst_valid", WIDTH'(out_valid), 0);

        // Single transfer, dvalid high 3 cycles
        step(1, 1, 32'hA5A5_0001, 0);
        chk("single_valid_1cyc", WIDTH'(out_valid), 1);
        chk("single_data", out_data, 32'hA5A5_0001);
        step(1, 1, 32'hA5A5_0001, 0);
        step(1, 1, 32'hA5A5_0001, 0);
        step(1, 0, 32'hA5A5_0001, 0);
        chk("single_count", WIDTH'(count), 1);
        chk("single_busy", WIDTH'(dbusy), 0);
        pop_expect(32'hA5A5_0001);

        // Fill to back-pressure
        xfer(1, 1, 0); xfer(2, 2, 0); xfer(3, 1, 0);
        chk("fill3_count", WIDTH'(count), 3);
        chk("fill3_busy", WIDTH'(dbusy), 1);
        xfer(4, 1, 0);
        chk("fill4_count", WIDTH'(count), 4);

        // Overflow
        xfer(32'hDEAD, 2, 0);
        chk("ovf_count", WIDTH'(count), 4);
        chk("ovf_flag", WIDTH'(overflow), 1);
`ifdef HS_RX_DROP_CNT_EN
        chk("ovf_drops", WIDTH'(drop_cnt), 1);
`else
        chk("ovf_drops", WIDTH'(drop_cnt), 0);
`endif

        // Full with simultaneous push and pop
        chk("simul_head", out_data, 1);
        step(1, 1, 32'h55, 1);
        chk("simul_count", WIDTH'(count), 4);
        step(1, 0, 32'h55, 0);
        pop_expect(2); pop_expect(3); pop_expect(4); pop_expect(32'h55);
        chk("drained", WIDTH'(out_valid), 0);

        // Wrap-around streaming
        step(0, 0, '0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, WIDTH'(i), 1);
            chk("stream_data", out_data, WIDTH'(i));
            chk("stream_cnt_le1", WIDTH'(count <= 1), 1);
            step(1, 0, WIDTH'(i), 1);
        end
        chk("stream_ovf", WIDTH'(overflow), 0);

        // Reset mid-stream with dvalid held high
        xfer(32'hA, 1, 0);
        step(1, 1, 32'hB, 0);
        chk("mid_count2", WIDTH'(count), 2);
        step(0, 1, 32'hB, 0);
        chk("mid_rst_count", WIDTH'(count), 0);
        chk("mid_rst_busy", WIDTH'(dbusy), 0);
        step(1, 1, 32'hB, 0);
        chk("mid_recap_count", WIDTH'(count), 1);
        chk("mid_recap_data", out_data, 32'hB);
        step(1, 1, 32'hB, 0);
        chk("mid_once", WIDTH'(count), 1);
        step(1, 0, 32'hB, 0);

        // Randomized traffic
        dv = 0; d = $urandom;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                dv = ~dv;
                if (dv) d = $urandom;
            end
            step(($urandom_range(0, 199) != 0), dv, d, ($urandom_range(0, 3) == 0));
            if (!rst_n) dv = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
